data_mem_resp: RTL and testbench
================================

// Module: data_mem_resp
// PURPOSE
//  Responder (slave) end of the core's data-memory req/gnt/r_valid handshake.
//  Sits outside proc and connects directly to its data_* ports.
//  Holds a word-addressed single-port RAM.
//  Grant and read latencies are configurable so the bench can stress the core's wait states.
//  One outstanding transaction at a time.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words (power of two)
//  BASE_ADDR    32'h0010_0000 byte address of word 0
//  GNT_LAT      0             cycles req must be held before gnt (0..15)
//  RD_LAT       1             cycles from accepted request to r_valid (1..15)
// PORTS
//  clk                in   1   clock, all state on rising edge
//  res                in   1   asynchronous, active-high reset
//  data_req           in   1   request from core
//  data_adr           in   32  byte address; bits [1:0] ignored
//  data_write         in   32  write data
//  data_write_enable  in   1   1 = store, 0 = load
//  data_gnt           out  1   request accepted this cycle
//  data_r_valid       out  1   one-cycle response strobe
//  data_read          out  32  load data, valid only with r_valid
//  data_err           out  1   out-of-range access, valid only with r_valid
// BEHAVIOUR
//  Reset: state=IDLE, counters=0, data_gnt=0, data_r_valid=0, data_read=0, data_err=0.
//   RAM contents are not cleared.
//   Reset asserted mid-transaction aborts it immediately; a pending write that was already granted stays committed.
//  FSM IDLE -> GNT_WAIT -> RESP_WAIT -> IDLE.
//  IDLE: on data_req=1 load gnt counter = GNT_LAT.
//   If GNT_LAT==0, grant in the same cycle: data_gnt = data_req (combinational from state).
//   Otherwise go to GNT_WAIT.
//  GNT_WAIT: decrement counter while data_req=1.
//   If data_req drops, return to IDLE; no access happens.
//   When the counter hits 0 and data_req=1, assert data_gnt.
//  Accept = data_req & data_gnt. At the accept edge:
//   - capture adr and we;
//   - perform the RAM write if we=1 and the address is in range;
//   - load resp counter = RD_LAT - 1;
//   - go to RESP_WAIT.
//  RESP_WAIT: data_gnt forced 0; decrement the counter.
//   At 0, data_r_valid=1 for exactly one cycle, then return to IDLE.
//  Latency: accept edge to r_valid is exactly RD_LAT cycles.
//   RD_LAT=1 gives r_valid in the cycle after gnt.
//   Back-to-back requests therefore see gnt at the earliest in the cycle after r_valid.
//  Stores also get an r_valid pulse, with data_read=0.
//  Loads: data_read = RAM[idx] with r_valid; data_read = 0 whenever r_valid=0.
//  Range: idx = (adr - BASE_ADDR) >> 2.
//   In range iff adr >= BASE_ADDR and idx < DEPTH_WORDS; unsigned 32-bit compare, no wrap.
//   The top-of-memory word is legal; the word after it is not.
//   Out-of-range store: write suppressed, data_err=1 with r_valid.
//   Out-of-range load: data_read = 32'hDEAD_BEEF, data_err=1.
//  A write followed by a read of the same word returns the new value (write commits at the accept edge).
//  Changes to adr/wdata/we after accept are ignored.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/GNT_WAIT/RESP_WAIT) and the constant 32'hDEAD_BEEF.
//  Sub-module dmem_array:
//   - sync single-port RAM: clk, we, idx, wdata, rdata;
//   - read is registered at the accept edge;
//   - rdata is held in the responder until r_valid.
//  Counters: 4 bits each.
// TESTING
//  1. GNT_LAT=0, RD_LAT=1: store 32'h1234_5678 to BASE_ADDR+8, then load it.
//     -> gnt in the request cycle; r_valid next cycle; data_read=32'h1234_5678; err=0.
//  2. GNT_LAT=3, RD_LAT=4: load with req held.
//     -> gnt 3 cycles after req rises; r_valid exactly 4 cycles after the accept edge.
//  3. GNT_LAT=3: drop req after 1 cycle.
//     -> no gnt, no r_valid, RAM unchanged; next req restarts the full 3-cycle count.
//  4. Load BASE_ADDR+4*(DEPTH_WORDS-1) -> err=0.
//     Load BASE_ADDR+4*DEPTH_WORDS and BASE_ADDR-4 -> err=1, data=32'hDEAD_BEEF.
//     Store there -> err=1, RAM unchanged.
//  5. Pulse res during RESP_WAIT of a store of 32'hCAFE_0001.
//     -> gnt/r_valid go 0 immediately, no r_valid after release; a later load returns 32'hCAFE_0001.
//  6. Hold req high continuously over 3 loads.
//     -> gnt never coincides with RESP_WAIT; one r_valid per gnt, in order.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encoding, counter width, error read-back pattern and the address range check.
package data_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_WAIT  = 2'd1,
        RESP_WAIT = 2'd2
    } state_e;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef logic [CNT_W-1:0] cnt_t;

    // Unsigned compare on the raw address first, so addresses below the base never wrap into range.
    function automatic logic addr_in_range(input logic [31:0] adr, input logic [31:0] base,
                                           input int unsigned depth);
        logic [31:0] offs;
        offs = adr - base;
        return (adr >= base) && ((offs >> 2) < 32'(depth));
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Core data-memory bus: req/gnt handshake with a one-cycle r_valid response strobe.
interface data_mem_if;
    logic        data_req;
    logic [31:0] data_adr;
    logic [31:0] data_write;
    logic        data_write_enable;
    logic        data_gnt;
    logic        data_r_valid;
    logic [31:0] data_read;
    logic        data_err;

    modport master (
        output data_req, data_adr, data_write, data_write_enable,
        input  data_gnt, data_r_valid, data_read, data_err
    );

    modport slave (
        input  data_req, data_adr, data_write, data_write_enable,
        output data_gnt, data_r_valid, data_read, data_err
    );
endinterface

// File: rtl/data_mem_resp_dmem_array.sv
// Word-addressed synchronous single-port RAM with a registered read port.
// Contents are never reset.
module dmem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int          IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Read-before-write: a store's own cycle returns the old word, which stores never use.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: programmable grant and read latency, one transaction in flight.
// Range-checks each access and reports out-of-range ones through data_err.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned GNT_LAT     = 0,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic       clk,
    input  logic       res,
    data_mem_if.slave  bus
);
    localparam int   IDX_W    = $clog2(DEPTH_WORDS);
    // The IDLE cycle that sees req already counts as the first wait cycle.
    localparam cnt_t GNT_LOAD = (GNT_LAT == 0) ? '0 : cnt_t'(GNT_LAT - 1);
    localparam cnt_t RD_LOAD  = cnt_t'(RD_LAT - 1);

    state_e           state_q, state_d;
    cnt_t             gcnt_q, gcnt_d;
    cnt_t             rcnt_q, rcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic             r_valid_q, r_valid_d;

    logic [31:0]      offs;
    logic             in_rng;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_rdata;
    logic             ram_we;
    logic             gnt;
    logic             accept;

    assign offs    = bus.data_adr - BASE_ADDR;
    assign in_rng  = addr_in_range(bus.data_adr, BASE_ADDR, DEPTH_WORDS);
    assign req_idx = offs[IDX_W+1:2];

    always_comb begin
        gnt = 1'b0;
        if (!res && bus.data_req) begin
            case (state_q)
                IDLE:     gnt = (GNT_LAT == 0);
                GNT_WAIT: gnt = (gcnt_q == '0);
                default:  gnt = 1'b0;
            endcase
        end
    end

    assign accept = bus.data_req & gnt;
    assign ram_we = accept & bus.data_write_enable & in_rng;
    // While waiting, keep re-reading the captured word so the RAM output holds it until r_valid.
    assign ram_idx = (state_q == RESP_WAIT) ? idx_q : req_idx;

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        rcnt_d  = rcnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.data_req && !accept) begin
                    state_d = GNT_WAIT;
                    gcnt_d  = GNT_LOAD;
                end
            end
            GNT_WAIT: begin
                if (!bus.data_req)  state_d = IDLE;
                else if (!accept)   gcnt_d  = gcnt_q - 1'b1;
            end
            RESP_WAIT: begin
                if (rcnt_q == '0) state_d = IDLE;
                else              rcnt_d  = rcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = RESP_WAIT;
            rcnt_d  = RD_LOAD;
            idx_d   = req_idx;
            we_d    = bus.data_write_enable;
            err_d   = !in_rng;
        end
        r_valid_d = (state_d == RESP_WAIT) && (rcnt_d == '0);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= IDLE;
            gcnt_q    <= '0;
            rcnt_q    <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            rcnt_q    <= rcnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            err_q     <= err_d;
            r_valid_q <= r_valid_d;
        end
    end

    dmem_array #(.DEPTH(DEPTH_WORDS)) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (bus.data_write),
        .rdata (ram_rdata)
    );

    assign bus.data_gnt     = gnt;
    assign bus.data_r_valid = r_valid_q;
    assign bus.data_err     = r_valid_q & err_q;

    always_comb begin
        bus.data_read = '0;
        if (r_valid_q && !we_q) bus.data_read = err_q ? ERR_DATA : ram_rdata;
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: two instances (GNT_LAT=0/RD_LAT=1 and GNT_LAT=3/RD_LAT=4) sharing one driver.
// Table of transactions plus hand sequences for abort, reset and back-to-back requests.
module tb_data_mem_resp;
    localparam logic [31:0] B = 32'h0010_0000;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          gl;
        int          rl;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdata = '0;
    logic        gnt_o, rv_o, err_o;
    logic [31:0] rd_o;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    data_mem_if if0();
    data_mem_if if1();

    assign if0.data_req          = req & ~sel;
    assign if1.data_req          = req & sel;
    assign if0.data_adr          = adr;
    assign if1.data_adr          = adr;
    assign if0.data_write        = wdata;
    assign if1.data_write        = wdata;
    assign if0.data_write_enable = we;
    assign if1.data_write_enable = we;

    assign gnt_o = sel ? if1.data_gnt     : if0.data_gnt;
    assign rv_o  = sel ? if1.data_r_valid : if0.data_r_valid;
    assign err_o = sel ? if1.data_err     : if0.data_err;
    assign rd_o  = sel ? if1.data_read    : if0.data_read;

    data_mem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(B), .GNT_LAT(0), .RD_LAT(1)) dut0 (
        .clk(clk), .res(res), .bus(if0.slave));
    data_mem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(B), .GNT_LAT(3), .RD_LAT(4)) dut1 (
        .clk(clk), .res(res), .bus(if1.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, "_data"}, rd_o, e.data);
            chk({nm, "_err"}, {31'b0, err_o}, {31'b0, e.err});
        end
    endtask

    function automatic vec_t mkv(input logic s, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.sel = s; v.we = w; v.adr = a; v.wdata = d; v.exp_data = ed; v.exp_err = ee;
        v.gl = s ? 3 : 0;
        v.rl = s ? 4 : 1;
        return v;
    endfunction

    task automatic run_xact(input vec_t v);
        int   cyc;
        bit   hit;
        exp_t e;
        @(posedge clk); #1;
        sel = v.sel; req = 1'b1; we = v.we; adr = v.adr; wdata = v.wdata;
        sb.push_back('{data: v.exp_data, err: v.exp_err});
        cyc = 0; hit = 0;
        while (!hit && cyc < 20) begin
            @(negedge clk);
            if (gnt_o) hit = 1; else cyc++;
        end
        chk("gnt_lat", 32'(cyc), 32'(v.gl));
        @(posedge clk); #1;
        // Scramble the bus after accept; the response must not depend on it.
        req = 1'b0; we = ~we; adr = $urandom; wdata = $urandom;
        if (!hit) begin
            e = sb.pop_back();
            return;
        end
        cyc = 1; hit = 0;
        while (!hit && cyc < 20) begin
            @(negedge clk);
            if (rv_o) hit = 1; else cyc++;
        end
        chk("rd_lat", 32'(cyc), 32'(v.rl));
        if (hit) sb_check("xact");
        else     e = sb.pop_front();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        bit seen_g, seen_r, hit;
        int cyc, k, nrv, outst;
        logic [31:0] a6 [3];
        logic [31:0] e6 [3];

        // Reset state of both instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", {31'b0, gnt_o}, 32'd0);
        chk("rst_rv0",  {31'b0, rv_o},  32'd0);
        chk("rst_rd0",  rd_o,           32'd0);
        chk("rst_err0", {31'b0, err_o}, 32'd0);
        sel = 1'b1; #1;
        chk("rst_rv1",  {31'b0, rv_o},  32'd0);
        chk("rst_rd1",  rd_o,           32'd0);
        @(posedge clk); #1;
        res = 1'b0;

        vecs.push_back(mkv(0, 1, B + 32'h08, 32'h1234_5678, 32'h0,          0));
        vecs.push_back(mkv(0, 0, B + 32'h08, 32'h0,         32'h1234_5678, 0));
        vecs.push_back(mkv(0, 1, B,          32'h0000_AAAA, 32'h0,          0));
        vecs.push_back(mkv(0, 1, B + 32'h3C, 32'h7777_0001, 32'h0,          0));
        vecs.push_back(mkv(0, 0, B + 32'h3C, 32'h0,         32'h7777_0001, 0));
        vecs.push_back(mkv(0, 0, B + 32'h40, 32'h0,         32'hDEAD_BEEF, 1));
        vecs.push_back(mkv(0, 0, B - 32'h04, 32'h0,         32'hDEAD_BEEF, 1));
        vecs.push_back(mkv(0, 1, B + 32'h40, 32'h5555_5555, 32'h0,          1));
        vecs.push_back(mkv(0, 1, B - 32'h04, 32'h6666_6666, 32'h0,          1));
        vecs.push_back(mkv(0, 0, B,          32'h0,         32'h0000_AAAA, 0));
        vecs.push_back(mkv(0, 0, B + 32'h3C, 32'h0,         32'h7777_0001, 0));
        vecs.push_back(mkv(1, 1, B + 32'h10, 32'hA5A5_0F0F, 32'h0,          0));
        vecs.push_back(mkv(1, 0, B + 32'h10, 32'h0,         32'hA5A5_0F0F, 0));
        foreach (vecs[i]) run_xact(vecs[i]);

        // Request dropped during the grant wait: nothing happens, next request counts from scratch
        @(posedge clk); #1;
        sel = 1'b1; req = 1'b1; we = 1'b1; adr = B + 32'h10; wdata = 32'hDEAD_0000;
        seen_g = 0; seen_r = 0;
        @(negedge clk); seen_g |= gnt_o;
        @(posedge clk); #1; req = 1'b0;
        repeat (8) begin
            @(negedge clk); seen_g |= gnt_o; seen_r |= rv_o;
        end
        chk("abort_gnt", {31'b0, seen_g}, 32'd0);
        chk("abort_rv",  {31'b0, seen_r}, 32'd0);
        run_xact(mkv(1, 0, B + 32'h10, 32'h0, 32'hA5A5_0F0F, 0));

        // Reset pulse while a granted store waits for its response
        @(posedge clk); #1;
        sel = 1'b1; req = 1'b1; we = 1'b1; adr = B + 32'h14; wdata = 32'hCAFE_0001;
        cyc = 0; hit = 0;
        while (!hit && cyc < 20) begin
            @(negedge clk);
            if (gnt_o) hit = 1; else cyc++;
        end
        chk("rst_store_gnt_lat", 32'(cyc), 32'd3);
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #2;
        res = 1'b1; #1;
        chk("midrst_rv1", {31'b0, rv_o}, 32'd0);
        sel = 1'b0; req = 1'b1; #1;
        chk("midrst_gnt0", {31'b0, gnt_o}, 32'd0);
        req = 1'b0; sel = 1'b1;
        @(posedge clk); #1; res = 1'b0;
        seen_r = 0;
        repeat (8) begin
            @(negedge clk); seen_r |= rv_o;
        end
        chk("midrst_no_rv", {31'b0, seen_r}, 32'd0);
        run_xact(mkv(1, 0, B + 32'h14, 32'h0, 32'hCAFE_0001, 0));

        // Three loads with req held high throughout
        a6[0] = B + 32'h08; a6[1] = B + 32'h3C; a6[2] = B;
        e6[0] = 32'h1234_5678; e6[1] = 32'h7777_0001; e6[2] = 32'h0000_AAAA;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0; req = 1'b1; adr = a6[0];
        sb.push_back('{data: e6[0], err: 1'b0});
        k = 1; nrv = 0; outst = 0; cyc = 0;
        while (nrv < 3 && cyc < 40) begin
            @(negedge clk);
            seen_g = gnt_o;
            if (gnt_o) begin
                chk("b2b_gnt_idle", 32'(outst), 32'd0);
                outst = 1;
            end
            if (rv_o) begin
                sb_check("b2b");
                outst = 0;
                nrv++;
            end
            @(posedge clk); #1;
            if (seen_g) begin
                if (k < 3) begin
                    adr = a6[k];
                    sb.push_back('{data: e6[k], err: 1'b0});
                    k++;
                end else begin
                    req = 1'b0;
                end
            end
            cyc++;
        end
        req = 1'b0;
        chk("b2b_count", 32'(nrv), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
